code_word_ser: RTL and testbench
================================

Name: code_word_ser

Overview:
- Consumer side of the codeword generator's parallel output bus.
- Captures one full codeword set (DEPTH even rows plus DEPTH odd rows, each row ANTS x WIDTH bits) when the generator asserts valid.
- Replays the set as a row-serial valid/ready stream with row index, even/odd tag and last marker.
- Feeds the beam-weight RAM loader upstream of the dimension-reduction multipliers.

Parameters:
- ANTS, 32, antennas per codeword row.
- WIDTH, 32, bits per antenna element (complex I/Q packed, treated as opaque).
- DEPTH, 64, rows per even set and rows per odd set; power of two, >= 2.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous reset, active-low.
- i_cw_even  in  [DEPTH-1:0][WIDTH*ANTS-1:0]  even codeword set.
- i_cw_odd  in  [DEPTH-1:0][WIDTH*ANTS-1:0]  odd codeword set.
- i_tvalid  in  1  set valid. Level or pulse; only sampled when the capture condition holds.
- o_tdata  out  WIDTH*ANTS  current row.
- o_tvalid  out  1  row valid.
- i_tready  in  1  downstream ready.
- o_tlast  out  1  high on final beat (beat 2*DEPTH-1).
- o_tuser  out  $clog2(DEPTH)+1  {odd flag, row index}.
- o_busy  out  1  high while the FSM is in ST_STREAM.
- o_overflow  out  1  one-cycle pulse: an i_tvalid was ignored.

Behaviour:
- Reset (i_reset==0 at posedge):
  - FSM to ST_IDLE; beat counter 0.
  - o_tvalid, o_tlast, o_busy, o_overflow = 0; o_tuser = 0; o_tdata = 0.
  - Capture registers need not be cleared.
  - Reset mid-stream abandons the set; no further beats are emitted.
- Beat order: beat b (0..2*DEPTH-1) selects row = b>>1 and odd = b[0]. Sequence is even0, odd0, even1, odd1, ..., odd(DEPTH-1).
- Handshake: a beat transfers on posedge with o_tvalid && i_tready.
- Capture condition: (state==ST_IDLE) OR (state==ST_STREAM AND the last beat transfers this cycle).
- ST_IDLE:
  - If i_tvalid, capture both sets and go to ST_STREAM.
  - Latency: capture at edge N → o_tvalid=1 with beat 0 from the cycle after edge N (one-cycle latency).
- ST_STREAM:
  - o_tvalid=1.
  - While i_tready==0: o_tdata, o_tuser, o_tlast are held stable.
  - On transfer of a non-last beat: beat counter +1.
  - On transfer of beat 2*DEPTH-1:
    - If i_tvalid is high in the same cycle: recapture, counter to 0, stay in ST_STREAM. Back-to-back sets, no bubble.
    - Else: go to ST_IDLE; o_tvalid=0 next cycle.
- Overflow: i_tvalid high while the capture condition is false → set not captured; o_overflow=1 for the next cycle. The current stream is unaffected.
- i_tvalid held high continuously in ST_IDLE captures only once, then overflows each cycle until the last beat. The bench checks this.
- o_tdata, o_tuser and o_tlast are registered, not a combinational mux off the counter. The next beat is preloaded on transfer so that full throughput is one beat per cycle.
- The counter never wraps outside a capture; no arithmetic beyond counter increment.

Decomposition:
- Package cw_pkg:
  - state enum {ST_IDLE, ST_STREAM}.
  - Localparams BEATS = 2*DEPTH, BEAT_W = $clog2(BEATS), ROW_W = $clog2(DEPTH).
  - Function beat_to_tuser.
- One natural sub-module, cw_row_sel: registered 2*DEPTH:1 row multiplexer driven by the beat index. It isolates the wide mux for timing and retiming.
- FSM, counter and handshake logic stay in code_word_ser.

Test Plan:
- Reset check: hold i_reset=0 for 3 cycles, then release with no i_tvalid → o_tvalid=0, o_busy=0, o_tuser=0, o_overflow=0.
- Full stream: even row r = 32'h0000_0000+r per antenna, odd = 32'h8000_0000+r; i_tvalid pulse; i_tready=1.
  - o_tvalid rises 1 cycle later.
  - 128 consecutive beats in even0, odd0, ... order; o_tuser = {b[0], b>>1}.
  - o_tlast only on beat 127; o_tvalid=0 on the cycle after.
- Backpressure: i_tready random, 50% duty → same 128-beat sequence, no duplicates or drops; data, tuser and tlast stable across every stall.
- Back-to-back: second i_tvalid coincident with the beat-127 transfer → beat 0 of the new set on the next cycle; o_tvalid never drops; o_overflow=0.
- Overflow: i_tvalid pulse at beat 40 → o_overflow pulses once; the stream continues with the original data through beat 127, then goes idle.
- Mid-stream reset: i_reset=0 at beat 70 → o_tvalid=0 the next cycle; after release, a fresh i_tvalid restarts at beat 0 with the new data.

Source files
------------

// File: rtl/code_word_ser_pkg.sv
// Shared types, default sizing and the beat-to-tuser mapping for the
// codeword serialiser.
package cw_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } state_t;

  // Default configuration (DEPTH = 64); modules derive their own widths
  // from their DEPTH parameter.
  localparam int unsigned CW_DEPTH = 64;
  localparam int unsigned BEATS    = 2 * CW_DEPTH;
  localparam int unsigned BEAT_W   = $clog2(BEATS);
  localparam int unsigned ROW_W    = $clog2(CW_DEPTH);

  // Beat b maps to {odd flag = b[0], row index = b >> 1}; the odd flag sits
  // at bit position row_w. The caller truncates to row_w+1 bits.
  function automatic logic [31:0] beat_to_tuser(input logic [31:0] beat,
                                                input int unsigned row_w);
    return (32'(beat[0]) << row_w) | (beat >> 1);
  endfunction

endpackage

// File: rtl/code_word_ser_if.sv
// Row-serial stream bundle: data/valid/ready/last/user plus status flags.
interface code_word_ser_if #(
  parameter int unsigned DATA_W = 1024,
  parameter int unsigned USER_W = 7
) (
  input logic clk
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [USER_W-1:0] tuser;
  logic              busy;
  logic              overflow;

  modport master (
    input  clk,
    input  tready,
    output tdata, tvalid, tlast, tuser, busy, overflow
  );

  modport slave (
    input  clk,
    input  tdata, tvalid, tlast, tuser, busy, overflow,
    output tready
  );

endinterface

// File: rtl/code_word_ser_row_sel.sv
// Registered 2*DEPTH:1 row multiplexer. Kept separate so the wide mux can be
// placed and retimed on its own.
module cw_row_sel #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned ROW_BITS = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           load_i,
  input  logic                           first_i,
  input  logic [ROW_BITS-1:0]            row0_i,
  input  logic [DEPTH-1:0][ROW_BITS-1:0] even_i,
  input  logic [DEPTH-1:0][ROW_BITS-1:0] odd_i,
  input  logic [$clog2(2*DEPTH)-1:0]     beat_i,
  output logic [ROW_BITS-1:0]            row_o
);

  localparam int unsigned BEAT_W = $clog2(2 * DEPTH);

  logic [ROW_BITS-1:0] row_q, row_d;
  logic [BEAT_W-2:0]   row_idx;

  // On a capture the stored sets are not yet valid, so beat 0 (even row 0)
  // comes straight from the input bus; all later beats read the stored sets.
  always_comb begin
    row_idx = beat_i[BEAT_W-1:1];
    if (first_i) begin
      row_d = row0_i;
    end else if (beat_i[0]) begin
      row_d = odd_i[row_idx];
    end else begin
      row_d = even_i[row_idx];
    end
  end

  // Output row register, updated only when a new beat is presented.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      row_q <= '0;
    end else if (load_i) begin
      row_q <= row_d;
    end
  end

  assign row_o = row_q;

endmodule

// File: rtl/code_word_ser.sv
// Captures a full even/odd codeword set and replays it as a row-serial
// valid/ready stream: even0, odd0, even1, odd1, ... odd(DEPTH-1).
module code_word_ser
  import cw_pkg::*;
#(
  parameter int unsigned ANTS  = 32,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic [DEPTH-1:0][WIDTH*ANTS-1:0]     i_cw_even,
  input  logic [DEPTH-1:0][WIDTH*ANTS-1:0]     i_cw_odd,
  input  logic                                 i_tvalid,
  output logic [WIDTH*ANTS-1:0]                o_tdata,
  output logic                                 o_tvalid,
  input  logic                                 i_tready,
  output logic                                 o_tlast,
  output logic [$clog2(DEPTH):0]               o_tuser,
  output logic                                 o_busy,
  output logic                                 o_overflow
);

  localparam int unsigned ROW_BITS = WIDTH * ANTS;
  localparam int unsigned N_BEATS  = 2 * DEPTH;
  localparam int unsigned CNT_W    = $clog2(N_BEATS);
  localparam int unsigned IDX_W    = $clog2(DEPTH);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [IDX_W:0]   tuser_t;

  localparam cnt_t LAST_BEAT = cnt_t'(N_BEATS - 1);

  state_t                         state_q, state_d;
  cnt_t                           cnt_q, cnt_d;
  logic                           tlast_q, tlast_d;
  tuser_t                         tuser_q, tuser_d;
  logic                           ovf_q, ovf_d;
  logic [DEPTH-1:0][ROW_BITS-1:0] even_q, odd_q;

  logic xfer, last_xfer, cap_ok, capture, load;

  // Handshake, capture decision, next state and next beat sideband.
  always_comb begin
    xfer      = (state_q == ST_STREAM) && i_tready;
    last_xfer = xfer && (cnt_q == LAST_BEAT);
    cap_ok    = (state_q == ST_IDLE) || last_xfer;
    capture   = cap_ok && i_tvalid;
    load      = capture || (xfer && !last_xfer);

    state_d = state_q;
    cnt_d   = cnt_q;
    tlast_d = tlast_q;
    tuser_d = tuser_q;
    ovf_d   = i_tvalid && !cap_ok;

    case (state_q)
      ST_IDLE:   if (capture) state_d = ST_STREAM;
      ST_STREAM: if (last_xfer && !i_tvalid) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (capture) begin
      cnt_d = '0;
    end else if (xfer && !last_xfer) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Sideband is preloaded alongside the row so a transfer presents the
    // following beat on the very next cycle.
    if (load) begin
      tlast_d = (cnt_d == LAST_BEAT);
      tuser_d = tuser_t'(beat_to_tuser(32'(cnt_d), IDX_W));
    end else if (state_d == ST_IDLE) begin
      tlast_d = 1'b0;
      tuser_d = '0;
    end
  end

  // State, beat counter and registered sideband outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tlast_q <= 1'b0;
      tuser_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tlast_q <= tlast_d;
      tuser_q <= tuser_d;
      ovf_q   <= ovf_d;
    end
  end

  // Capture storage for both sets; contents are don't-care until captured.
  always_ff @(posedge i_clk) begin
    if (capture) begin
      even_q <= i_cw_even;
      odd_q  <= i_cw_odd;
    end
  end

  cw_row_sel #(
    .DEPTH    (DEPTH),
    .ROW_BITS (ROW_BITS)
  ) u_row_sel (
    .clk_i   (i_clk),
    .rst_ni  (i_reset),
    .load_i  (load),
    .first_i (capture),
    .row0_i  (i_cw_even[0]),
    .even_i  (even_q),
    .odd_i   (odd_q),
    .beat_i  (cnt_d),
    .row_o   (o_tdata)
  );

  assign o_tvalid   = (state_q == ST_STREAM);
  assign o_busy     = (state_q == ST_STREAM);
  assign o_tlast    = tlast_q;
  assign o_tuser    = tuser_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_code_word_ser.sv
// Directed bench for code_word_ser at default sizing (32x32-bit rows, 64+64 rows).
module tb_code_word_ser;
  import cw_pkg::*;

  localparam int NB = int'(BEATS);   // 128 beats per set

  logic clk = 1'b0;
  logic rst_n;
  logic [63:0][1023:0] cw_even, cw_odd;
  logic tvalid_in;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  code_word_ser_if #(.DATA_W(1024), .USER_W(7)) bus (.clk(clk));

  code_word_ser #(
    .ANTS  (32),
    .WIDTH (32),
    .DEPTH (64)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_cw_even  (cw_even),
    .i_cw_odd   (cw_odd),
    .i_tvalid   (tvalid_in),
    .o_tdata    (bus.tdata),
    .o_tvalid   (bus.tvalid),
    .i_tready   (bus.tready),
    .o_tlast    (bus.tlast),
    .o_tuser    (bus.tuser),
    .o_busy     (bus.busy),
    .o_overflow (bus.overflow)
  );

  task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Element a of beat b for stimulus set s.
  // Set 0: even 0x00000000+r, odd 0x80000000+r on every antenna.
  // Set 1: even 0x10000000+(a<<8)+r, odd 0x90000000+(a<<8)+r.
  // Set 2: even 0x40000000+(a<<16)+r, odd 0xC0000000+(a<<16)+r.
  function automatic logic [1023:0] exp_row(input int s, input int b);
    logic [1023:0] res;
    logic [31:0]   w, base;
    int            r;
    bit            odd;
    r   = b >> 1;
    odd = b[0];
    res = '0;
    for (int a = 0; a < 32; a++) begin
      case (s)
        0:       begin base = odd ? 32'h8000_0000 : 32'h0000_0000; w = base + 32'(r); end
        1:       begin base = odd ? 32'h9000_0000 : 32'h1000_0000; w = base + 32'(a << 8) + 32'(r); end
        default: begin base = odd ? 32'hC000_0000 : 32'h4000_0000; w = base + 32'(a << 16) + 32'(r); end
      endcase
      res[a*32 +: 32] = w;
    end
    return res;
  endfunction

  task automatic set_inputs(input int s);
    for (int r = 0; r < 64; r++) begin
      cw_even[r] = exp_row(s, 2 * r);
      cw_odd[r]  = exp_row(s, 2 * r + 1);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_tvalid"}, 1024'(bus.tvalid), 1024'(0));
    chk({tag, "_busy"},   1024'(bus.busy),   1024'(0));
  endtask

  // Single-cycle i_tvalid pulse from idle; beat 0 must be up right after.
  task automatic start(input int s);
    set_inputs(s);
    tvalid_in = 1'b1;
    tick;
    tvalid_in = 1'b0;
    chk("start_ovf", 1024'(bus.overflow), 1024'(0));
  endtask

  // Walk one set beat by beat, checking every presented beat.
  // bp: random ready; ovf_beat: inject an ignored i_tvalid at that beat;
  // nxt: recapture set nxt on the last transfer; rst_beat: reset at that beat.
  task automatic stream_set(input int s, input bit bp, input int ovf_beat,
                            input int nxt, input int rst_beat);
    int b = 0;
    int cyc = 0;
    bit rdy;
    bit exp_ovf;
    bit ovf_done = 1'b0;
    logic [6:0] exp_tu;
    while (b < NB && cyc < 2000) begin
      exp_tu = 7'((b[0] << 6) | (b >> 1));
      chk("tvalid", 1024'(bus.tvalid), 1024'(1));
      chk("busy",   1024'(bus.busy),   1024'(1));
      chk("tdata",  bus.tdata,         exp_row(s, b));
      chk("tuser",  1024'(bus.tuser),  1024'(exp_tu));
      chk("tlast",  1024'(bus.tlast),  1024'(b == NB - 1));
      if (b == rst_beat) begin
        rst_n = 1'b0;
        tick;
        return;
      end
      rdy = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.tready = rdy;
      exp_ovf = 1'b0;
      if (b == ovf_beat && !ovf_done) begin
        set_inputs(2);
        tvalid_in = 1'b1;
        exp_ovf   = 1'b1;
        ovf_done  = 1'b1;
      end
      if (b == NB - 1 && rdy && nxt >= 0) begin
        set_inputs(nxt);
        tvalid_in = 1'b1;
      end
      tick;
      tvalid_in = 1'b0;
      cyc++;
      chk("ovf", 1024'(bus.overflow), 1024'(exp_ovf));
      if (rdy) b++;
    end
    if (cyc >= 2000) chk("stream_timeout", 1024'(0), 1024'(1));
  endtask

  initial begin
    rst_n      = 1'b0;
    tvalid_in  = 1'b0;
    bus.tready = 1'b1;
    set_inputs(0);

    // Reset held 3 cycles, released with no i_tvalid.
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    check_idle("rst");
    chk("rst_tuser", 1024'(bus.tuser),    1024'(0));
    chk("rst_ovf",   1024'(bus.overflow), 1024'(0));
    chk("rst_tdata", bus.tdata,           1024'(0));
    chk("rst_tlast", 1024'(bus.tlast),    1024'(0));

    // Full stream, ready always high.
    start(0);
    stream_set(0, 1'b0, -1, -1, -1);
    check_idle("full_end");

    // Random backpressure.
    start(1);
    stream_set(1, 1'b1, -1, -1, -1);
    check_idle("bp_end");

    // Back-to-back sets: recapture on the last transfer, no bubble.
    start(0);
    stream_set(0, 1'b0, -1, 2, -1);
    stream_set(2, 1'b1, -1, -1, -1);
    check_idle("b2b_end");

    // Ignored i_tvalid at beat 40 pulses overflow once, stream unchanged.
    start(1);
    stream_set(1, 1'b0, 40, -1, -1);
    check_idle("ovf_end");
    tick;
    check_idle("ovf_stay");

    // i_tvalid held from idle: one capture, then overflow every cycle.
    set_inputs(2);
    bus.tready = 1'b0;
    tvalid_in  = 1'b1;
    tick;
    set_inputs(0);
    chk("hold_cap_ovf", 1024'(bus.overflow), 1024'(0));
    chk("hold_tvalid",  1024'(bus.tvalid),   1024'(1));
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("hold_ovf", 1024'(bus.overflow), 1024'(1));
    end
    tvalid_in = 1'b0;
    tick;
    chk("hold_ovf_clr", 1024'(bus.overflow), 1024'(0));
    stream_set(2, 1'b0, -1, -1, -1);
    check_idle("hold_end");

    // Reset at beat 70 abandons the set; a fresh capture restarts at beat 0.
    start(0);
    stream_set(0, 1'b0, -1, -1, 70);
    check_idle("mrst");
    chk("mrst_tlast", 1024'(bus.tlast), 1024'(0));
    chk("mrst_tuser", 1024'(bus.tuser), 1024'(0));
    chk("mrst_tdata", bus.tdata,        1024'(0));
    rst_n = 1'b1;
    tick;
    check_idle("mrst_rel");
    start(1);
    stream_set(1, 1'b0, -1, -1, -1);
    check_idle("mrst_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the bench cannot hang.
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
